// File: rtl/ysyx_25040111_lsu_axi_pkg.sv
// Shared FSM states, AXI constants and size encodings for the LSU AXI master.
package ysyx_25040111_lsu_axi_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // For size 3 the mask wraps to 3'b111, which is exactly the doubleword mask.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    return (addr_lo & ((3'd1 << size) - 3'd1)) != 3'd0;
  endfunction
endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Combinational lane steering: store data/strobe shift into a double-word window, load extract and extend.
// The upper half of each window is the second beat of a split access.
module ysyx_25040111_lsu_align
  import ysyx_25040111_lsu_axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]          size,
  input  logic [OFF_W-1:0]    off,
  input  logic                sign,
  input  logic [DATA_W-1:0]   wdata,
  output logic [2*DATA_W-1:0] wdata_wide,
  output logic [2*STRB_W-1:0] wstrb_wide,
  input  logic [2*DATA_W-1:0] rdata_wide,
  output logic [DATA_W-1:0]   rdata_ext
);
  logic [STRB_W-1:0] mask;
  logic [DATA_W-1:0] shifted;
  logic              msb;

  always_comb begin
    case (size)
      SIZE_B:  mask = STRB_W'(1'b1);
      SIZE_H:  mask = STRB_W'(2'b11);
      SIZE_W:  mask = STRB_W'(4'hF);
      default: mask = '1;
    endcase
    wstrb_wide = {{STRB_W{1'b0}}, mask} << off;
    wdata_wide = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
  end

  always_comb begin
    shifted = DATA_W'(rdata_wide >> {off, 3'b000});
    case (size)
      SIZE_B:  msb = shifted[7];
      SIZE_H:  msb = shifted[15];
      SIZE_W:  msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
    rdata_ext = '0;
    for (int i = 0; i < DATA_W; i++)
      rdata_ext[i] = (i < (8 << size)) ? shifted[i] : (sign & msb);
  end
endmodule

// File: rtl/ysyx_25040111_lsu_axi.sv
// Load/store unit with a single-outstanding AXI4 master; req_ready stays low until the response handshake.
// LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two beats; otherwise misaligned accesses fault.
module ysyx_25040111_lsu_axi
  import ysyx_25040111_lsu_axi_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic                req_sign,
  input  logic [1:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [3:0]          m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  input  logic [3:0]          m_bid,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [3:0]          m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic [3:0]          m_rid
);
  localparam int         STRB_W   = DATA_W / 8;
  localparam int         OFF_W    = $clog2(STRB_W);
  localparam logic [1:0] MAX_SIZE = 2'(OFF_W);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rbuf_lo;
  logic [1:0]          size_q;
  logic                sign_q, split_q, phase_q, err_q;
  logic                fault_now, split_now, bus_err;
  logic [OFF_W-1:0]    off;
  logic [ADDR_W-1:0]   base_addr, bus_addr;
  logic [2:0]          bus_size;
  logic [2*DATA_W-1:0] wdata_wide, rdata_wide;
  logic [2*STRB_W-1:0] wstrb_wide;
  logic [DATA_W-1:0]   rdata_ext;
  logic                unused_ids;

`ifdef LSU_MISALIGN_SPLIT_EN
  always_comb begin
    fault_now = req_size > MAX_SIZE;
    split_now = !fault_now && ((int'(req_addr[OFF_W-1:0]) + (1 << req_size)) > STRB_W);
  end
`else
  always_comb begin
    fault_now = (req_size > MAX_SIZE) || is_misaligned(req_addr[2:0], req_size);
    split_now = 1'b0;
  end
`endif

  // Split beats use full-width transfers at word-aligned addresses, low word first.
  assign off        = addr_q[OFF_W-1:0];
  assign base_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + (phase_q ? ADDR_W'(STRB_W) : '0);
  assign bus_addr   = split_q ? base_addr : addr_q;
  assign bus_size   = split_q ? 3'(OFF_W) : {1'b0, size_q};
  assign rdata_wide = phase_q ? {m_rdata, rbuf_lo} : {{DATA_W{1'b0}}, m_rdata};
  assign bus_err    = (state == S_R) ? (m_rresp != RESP_OKAY) : (m_bresp != RESP_OKAY);
  assign unused_ids = ^{m_bid, m_rid, m_rlast};

  assign m_awaddr  = bus_addr;
  assign m_awid    = AXI_ID;
  assign m_awlen   = 8'd0;
  assign m_awsize  = bus_size;
  assign m_awburst = BURST_INCR;
  assign m_wdata   = phase_q ? wdata_wide[2*DATA_W-1:DATA_W] : wdata_wide[DATA_W-1:0];
  assign m_wstrb   = phase_q ? wstrb_wide[2*STRB_W-1:STRB_W] : wstrb_wide[STRB_W-1:0];
  assign m_wlast   = 1'b1;
  assign m_araddr  = bus_addr;
  assign m_arid    = AXI_ID;
  assign m_arlen   = 8'd0;
  assign m_arsize  = bus_size;
  assign m_arburst = BURST_INCR;

  ysyx_25040111_lsu_align #(.DATA_W(DATA_W)) u_align (
    .size       (size_q),
    .off        (off),
    .sign       (sign_q),
    .wdata      (wdata_q),
    .wdata_wide (wdata_wide),
    .wstrb_wide (wstrb_wide),
    .rdata_wide (rdata_wide),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_lo    <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      split_q    <= 1'b0;
      phase_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          size_q    <= req_size;
          sign_q    <= req_sign;
          split_q   <= split_now;
          phase_q   <= 1'b0;
          err_q     <= 1'b0;
          if (fault_now) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (req_wen) begin
            state     <= S_AW_W;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
          end else begin
            state     <= S_AR;
            m_arvalid <= 1'b1;
          end
        end
        S_AR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          state     <= S_R;
        end
        S_R: if (m_rvalid) begin
          m_rready <= 1'b0;
          if (split_q && !phase_q) begin
            phase_q   <= 1'b1;
            rbuf_lo   <= m_rdata;
            err_q     <= err_q | bus_err;
            m_arvalid <= 1'b1;
            state     <= S_AR;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= err_q | bus_err;
            resp_rdata <= rdata_ext;
          end
        end
        S_AW_W: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if ((m_awready || !m_awvalid) && (m_wready || !m_wvalid)) begin
            m_bready <= 1'b1;
            state    <= S_B;
          end
        end
        S_B: if (m_bvalid) begin
          m_bready <= 1'b0;
          if (split_q && !phase_q) begin
            phase_q   <= 1'b1;
            err_q     <= err_q | bus_err;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            state     <= S_AW_W;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= err_q | bus_err;
            resp_rdata <= '0;
          end
        end
        S_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ysyx_25040111_lsu_axi.md
Name:
ysyx_25040111_lsu_axi
Overview:
- Parametrised load/store unit with a single-outstanding AXI4 master; successor to the fixed 32-bit LSU.
- Sits between EXU/WBU and the crossbar; does request→AXI transaction→aligned, sign-extended result.
- Adds DATA_W generalisation, req/resp valid-ready handshake, bus-error reporting, optional misaligned-access splitting.
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, bus/data width (32 or 64); STRB_W = DATA_W/8
- AXI_ID, 0, constant awid/arid value (4 bits)
Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request valid; req_ready  out  1  accepted when both high
- req_wen  in  1  1=store, 0=load
- req_sign  in  1  sign-extend load result
- req_size  in  2  log2 bytes: 0=B,1=H,2=W,3=D (D only if DATA_W=64)
- req_addr  in  ADDR_W  byte address; req_wdata  in  DATA_W  store data, LSB-aligned
- resp_valid  out  1; resp_ready  in  1  response handshake
- resp_rdata  out  DATA_W  extended load data (0 for stores)
- resp_err  out  1  SLVERR/DECERR seen, or misaligned fault
- m_aw{valid out 1, ready in 1, addr out ADDR_W, id out 4, len out 8, size out 3, burst out 2}
- m_w{valid out 1, ready in 1, data out DATA_W, strb out STRB_W, last out 1}
- m_b{valid in 1, ready out 1, resp in 2, id in 4}
- m_ar{valid out 1, ready in 1, addr out ADDR_W, id out 4, len out 8, size out 3, burst out 2}
- m_r{valid in 1, ready out 1, data in DATA_W, resp in 2, last in 1, id in 4}
Behaviour:
- Reset: state IDLE; all valid outputs 0; req_ready 1; resp_valid/resp_err 0; resp_rdata 0; m_bready/m_rready 0.
- FSM: IDLE→(load)AR→R→RESP; IDLE→(store)AW_W→B→RESP; RESP→IDLE on resp_ready.
- req_ready=1 only in IDLE; request fields latched on acceptance; inputs ignored afterwards.
- AR: arvalid held until arready; araddr=latched addr, arsize=req_size, arlen=0, arburst=INCR(01).
- AW_W: awvalid and wvalid asserted same cycle, each dropped independently on its ready; leave when both done (any order, incl. W before AW).
- wdata = wdata << 8*addr[log2 STRB_W-1:0]; wstrb = ((1<<(1<<size))-1) << same offset; wlast=1.
- R: rready=1; on rvalid capture rdata>>8*offset, truncate to size, extend by req_sign; B: bready=1.
- resp_err sticky for the transaction if any rresp/bresp ≠ 00; data still returned.
- resp_valid held with stable data until resp_ready; min latency accept→resp_valid = 3 cycles with zero-wait slave.
- size > log2 STRB_W: not accepted as bus op; RESP with resp_err=1 next cycle.
- Misaligned (addr mod (1<<size) ≠ 0) without feature: no bus traffic, RESP with resp_err=1.
- rst mid-transaction: immediate return to IDLE, all valids dropped; outstanding slave response not tracked.
Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: accesses crossing a DATA_W boundary split into two sequential single-beat transactions (low then high word, second addr = aligned+STRB_W); load bytes merged before extension; store strobes split; resp_err = OR of both.
- Undefined: misaligned accesses fault as above; any misaligned within one word also faults.
Decomposition:
- Shared header: FSM state encodings, AXI burst/resp constants (INCR=01, OKAY=00), size encodings.
- One sub-module ysyx_25040111_lsu_align: combinational wstrb/wdata shift and load extract/extend, reused for both halves of a split.
Test Plan:
- Load byte addr 0x8000_0003, req_sign=1, rdata 0x80xx_xxxx -> resp_rdata 0xFFFF_FF80, resp_err 0.
- Store half addr 0x8000_0002 wdata 0x1234 -> wstrb 1100, wdata 0x1234_0000, one B then resp_valid.
- Slave raises wready 2 cycles before awready -> single AW and single W, resp after B.
- rresp=10 on load -> resp_err 1, resp_valid held until resp_ready deasserts 3 cycles.
- Word load at 0x8000_0002: without macro resp_err 1 and no ARVALID; with macro two ARs (0x8000_0000, 0x8000_0004) and merged result.
- rst asserted while in AR with arvalid=1 -> arvalid 0 and req_ready 1 immediately.
